// File: rtl/swap_sched_pkg.sv
// Shared types and constants for the swap-register scheduler.
package swap_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} sched_state_t;

  localparam logic ORDER_STRAIGHT = 1'b0;
  localparam logic ORDER_SWAP     = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first valid index at or after ptr_i, with wrap-around.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = W'((int'(ptr_i) + k) % int'(N));
      if (!any_o && valid_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/swap_reg_scheduler.sv
// Arbitrates NUM_REQ requesters onto one shared order-swap register and holds each grant
// for HOLD_CYCLES cycles. Define SWAP_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module swap_reg_scheduler
  import swap_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_order,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 data1,
  output logic                 data2,
  output logic                 order,
  output logic                 load,
  output logic [IDW-1:0]       gnt_id,
  output logic                 busy
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  sched_state_t   state_q, state_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           data1_q, data1_d, data2_q, data2_d, order_q, order_d;
  logic           load_q, load_d, busy_q, busy_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] rr_ptr;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               arb_en;

  rr_pick #(
    .N(NUM_REQ),
    .W(IDW)
  ) u_pick (
    .valid_i(req_valid),
    .ptr_i  (rr_ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign arb_en    = (state_q == IDLE) || (hold_cnt_q == '0);
  assign req_ready = (arb_en && !reset) ? pick_gnt : '0;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    order_d    = order_q;
    gnt_id_d   = gnt_id_q;
    load_d     = 1'b0;
    if (arb_en) begin
      if (pick_any) begin
        state_d    = ISSUE;
        hold_cnt_d = CW'(HOLD_CYCLES - 1);
        data1_d    = req_data[{pick_idx, 1'b1}];
        data2_d    = req_data[{pick_idx, 1'b0}];
        order_d    = req_order[pick_idx];
        gnt_id_d   = pick_idx;
        load_d     = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d    = HOLD;
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      data1_q    <= 1'b0;
      data2_q    <= 1'b0;
      order_q    <= ORDER_STRAIGHT;
      load_q     <= 1'b0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      order_q    <= order_d;
      load_q     <= load_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SWAP_SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer moves to the slot just past the winner, only when a grant happens.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (arb_en && pick_any) begin
      rr_ptr_d = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

  assign data1  = data1_q;
  assign data2  = data2_q;
  assign order  = order_q;
  assign load   = load_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
